instruction_fetch: RTL

Instruction fetch stage of the MIPS 32-bit CPU; sits directly upstream of the instruction memory. Owns the program counter and drives the word index into the instruction memory every cycle. Pairs the memory's registered instruction output with the PC it was fetched from, and presents both, with a valid flag, to the decode stage. Handles decode-stage stalls, branch/jump redirects and out-of-range fetch faults.

---
 rtl/instruction_fetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory index and pairs the
// returned instruction with its PC. Optional fetch counter enabled by defining FETCH_COUNT_EN.
module instruction_fetch #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned IMEM_SIZE = 128,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [DATA_BITS-1:0] redirect_target,
  output logic [DATA_BITS-1:0] index,
  input  logic [DATA_BITS-1:0] instruction_in,
  output logic [DATA_BITS-1:0] instruction_out,
  output logic [DATA_BITS-1:0] pc_out,
  output logic [DATA_BITS-1:0] pc_plus4_out,
  output logic                 valid_out,
  output logic                 fault,
  output logic [DATA_BITS-1:0] fault_pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]          fetch_count
`endif
);

  localparam logic [DATA_BITS-1:0] ResetPc   = DATA_BITS'(RESET_PC);
  localparam logic [DATA_BITS-1:0] ImemBytes = DATA_BITS'(IMEM_SIZE * 4);
  localparam logic [DATA_BITS-1:0] PcStep    = DATA_BITS'(4);

  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   fetch_pc_q, fetch_pc_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic [DATA_BITS-1:0]   fault_pc_q, fault_pc_d;
  logic [DATA_BITS-1:0]   next_pc;
  logic                   check_fail;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    next_pc    = fetch_pc_q;
    check_fail = 1'b0;
    case (state_q)
      StBoot: begin
        state_d = StRun;
        valid_d = 1'b1;
      end
      StRun: begin
        // Redirect outranks stall; a held PC is known good so it skips the range check.
        if (redirect) begin
          next_pc = redirect_target;
        end else if (!stall) begin
          next_pc = fetch_pc_q + PcStep;
        end
        check_fail = (next_pc != fetch_pc_q) &&
                     ((next_pc[1:0] != 2'b00) || (next_pc >= ImemBytes));
        if (check_fail) begin
          state_d    = StFault;
          fault_d    = 1'b1;
          fault_pc_d = next_pc;
          valid_d    = 1'b0;
        end else begin
          fetch_pc_d = next_pc;
        end
      end
      StFault: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      fetch_pc_q <= ResetPc;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Memory samples index on every edge, so reset must present the boot address.
  assign index           = reset_n ? (next_pc >> 2) : (ResetPc >> 2);
  assign instruction_out = instruction_in;
  assign pc_out          = fetch_pc_q;
  assign pc_plus4_out    = fetch_pc_q + PcStep;
  assign valid_out       = valid_q;
  assign fault           = fault_q;
  assign fault_pc        = fault_pc_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  // Counts instructions accepted by decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_count_q <= '0;
    end else if (valid_q && !stall) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
